// File: rtl/rr_grant_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : rr_grant_sched_pkg                                       |
// | Purpose : Shared constants and FSM state type for the round-robin  |
// |           grant scheduler and its one-hot decoder.                 |
// | Contents: NREQ (requester count), IDW (index width),               |
// |           MAX_HOLD_DEFAULT, state_t                                |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package rr_grant_sched_pkg;

  localparam int NREQ             = 8;
  localparam int IDW              = 3;
  localparam int MAX_HOLD_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/onehot_dec3to8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : onehot_dec3to8                                           |
// | Purpose : 3-to-8 one-hot decoder with enable; all-zero when the    |
// |           enable is low.                                           |
// | Ports   : idx    in  [IDW-1:0]  binary index                       |
// |           en     in  1          decode enable                      |
// |           onehot out [NREQ-1:0] one-hot result                     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module onehot_dec3to8
  import rr_grant_sched_pkg::*;
(
  input  logic [IDW-1:0]  idx,
  input  logic            en,
  output logic [NREQ-1:0] onehot
);

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_bit
      assign onehot[i] = en && (idx == IDW'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rr_grant_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : rr_grant_sched                                           |
// | Purpose : 8-way round-robin grant scheduler with a bounded hold    |
// |           time, one-cycle GAP between grants and timeout pulse.    |
// | Ports   : clk           in  1  rising-edge clock                   |
// |           rst_n         in  1  asynchronous active-low reset       |
// |           en            in  1  global enable (low revokes grant)   |
// |           req           in  8  level requests, bit i = requester i |
// |           release_pulse in  1  current grantee ends its grant      |
// |           grant         out 8  one-hot grant, zero when idle       |
// |           grant_id      out 3  index of grantee, 0 when idle       |
// |           grant_valid   out 1  high while a grant is held          |
// |           timeout       out 1  pulse: grant ended by hold limit    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module rr_grant_sched
  import rr_grant_sched_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            release_pulse,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid,
  output logic            timeout
);

  // Counter value on the last permitted grant cycle.
  localparam logic [7:0] C_CNT_LIMIT = 8'(MAX_HOLD - 1);

  state_t          r_state,   w_state_nxt;
  logic [IDW-1:0]  r_ptr,     w_ptr_nxt;
  logic [7:0]      r_cnt,     w_cnt_nxt;
  logic [IDW-1:0]  r_id,      w_id_nxt;
  logic            r_valid,   w_valid_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic [NREQ-1:0] r_grant,   w_grant_nxt;

  logic            w_rr_found;
  logic [IDW-1:0]  w_rr_idx;
  logic            w_end_other;
  logic            w_at_limit;

  // Round-robin search: indices ptr+1 .. ptr+8 (mod 8); the 3-bit add
  // wraps naturally, and k = 8 revisits ptr itself last.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_rr_found && req[r_ptr + IDW'(k)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = r_ptr + IDW'(k);
      end
    end
  end

  // Any exit cause other than the hold limit; these suppress timeout.
  assign w_end_other = release_pulse || !req[r_id] || !en;
  assign w_at_limit  = (r_cnt == C_CNT_LIMIT);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_id_nxt      = r_id;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en && w_rr_found) begin
          w_state_nxt = ST_GRANT;
          w_ptr_nxt   = w_rr_idx;
          w_id_nxt    = w_rr_idx;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_end_other || w_at_limit) begin
          w_state_nxt   = ST_GAP;
          w_id_nxt      = '0;
          w_valid_nxt   = 1'b0;
          w_cnt_nxt     = '0;
          w_timeout_nxt = w_at_limit && !w_end_other;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_id_nxt    = '0;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Decode the next grantee so the one-hot grant comes straight from a flop.
  onehot_dec3to8 u_dec (
    .idx    (w_id_nxt),
    .en     (w_valid_nxt),
    .onehot (w_grant_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '1;          // requester 0 searched first after reset
      r_cnt     <= '0;
      r_id      <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_grant   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_id      <= w_id_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_grant   <= w_grant_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_id;
  assign grant_valid = r_valid;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_rr_grant_sched                                        |
// | Purpose : Self-checking bench for rr_grant_sched: directed cases   |
// |           plus randomized traffic against a behavioural model.     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_rr_grant_sched;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       release_pulse;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the bus, for how many cycles, last winner.
  bit m_busy;
  bit m_gap;
  bit m_to;
  int m_owner;
  int m_held;
  int m_ptr;

  rr_grant_sched #(.MAX_HOLD(MH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .req           (req),
    .release_pulse (release_pulse),
    .grant         (grant),
    .grant_id      (grant_id),
    .grant_valid   (grant_valid),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_gap   = 1'b0;
    m_to    = 1'b0;
    m_owner = 0;
    m_held  = 0;
    m_ptr   = 7;
  endfunction

  // One clock edge of the rules: holder keeps the bus until release, its
  // request drops, enable drops or it has held MH cycles; then one quiet
  // cycle; then the next requester after the last winner gets the bus.
  function automatic void model_edge();
    bit lim;
    bit other;
    bit found;
    int c;
    m_to = 1'b0;
    if (m_busy) begin
      lim   = (m_held == MH);
      other = release_pulse || !req[m_owner] || !en;
      if (lim || other) begin
        m_busy = 1'b0;
        m_gap  = 1'b1;
        m_to   = lim && !other;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (en && req != 8'h00) begin
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        c = (m_ptr + k) % 8;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
      m_ptr  = m_owner;
      m_busy = 1'b1;
      m_held = 1;
    end
  endfunction

  task automatic compare_model();
    check_eq("grant",       grant,       m_busy ? (32'd1 << m_owner) : 32'd0);
    check_eq("grant_id",    grant_id,    m_busy ? 32'(m_owner) : 32'd0);
    check_eq("grant_valid", grant_valid, 32'(m_busy));
    check_eq("timeout",     timeout,     32'(m_to));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  // Assert reset off the clock edge, confirm outputs clear at once, then
  // release on the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_grant", grant, 32'h00);
    check_eq("rst_valid", grant_valid, 32'd0);
    check_eq("rst_id",    grant_id, 32'd0);
    check_eq("rst_to",    timeout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int bound);
    for (int c = 0; c < bound && !grant_valid; c++) step();
    check_eq("wait_grant", grant_valid, 32'd1);
  endtask

  initial begin
    int hold;
    rst_n         = 1'b0;
    en            = 1'b0;
    req           = 8'h00;
    release_pulse = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Two requesters at both ends: 0 first, then 7.
    en = 1'b1; req = 8'h81;
    step();
    check_eq("t030_g0", grant, 32'h01);
    check_eq("t030_id0", grant_id, 32'd0);
    release_pulse = 1'b1; step(); release_pulse = 1'b0;
    step();
    step();
    check_eq("t030_g7", grant, 32'h80);
    check_eq("t030_id7", grant_id, 32'd7);

    // Full rotation with wrap.
    do_reset();
    req = 8'hFF; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_grant(8);
      check_eq("t031_seq", grant_id, 32'(i % 8));
      step();
      step();
      release_pulse = 1'b1; step(); release_pulse = 1'b0;
    end

    // Hold limit forces exit with a timeout pulse.
    do_reset();
    req = 8'h04; en = 1'b1;
    step();
    hold = 0;
    while (grant == 8'h04 && hold < 20) begin
      hold++;
      step();
    end
    check_eq("t032_hold", 32'(hold), 32'(MH));
    check_eq("t032_to", timeout, 32'd1);
    step();
    check_eq("t032_to_clr", timeout, 32'd0);
    check_eq("t032_idle", grant_valid, 32'd0);
    step();
    check_eq("t032_regrant", grant, 32'h04);

    // Release coincides with the limit: no timeout.
    step(); step(); step();
    release_pulse = 1'b1; step(); release_pulse = 1'b0;
    check_eq("t035_valid", grant_valid, 32'd0);
    check_eq("t035_to", timeout, 32'd0);

    // Enable drop revokes the grant; search resumes after 3.
    do_reset();
    req = 8'h08; en = 1'b1;
    step();
    check_eq("t033_id3", grant_id, 32'd3);
    en = 1'b0; step();
    check_eq("t033_revoke", grant, 32'h00);
    check_eq("t033_to", timeout, 32'd0);
    en = 1'b1; req = 8'hFF;
    wait_grant(8);
    check_eq("t033_id4", grant_id, 32'd4);

    // Reset mid-grant, then the pointer follows the post-reset winner.
    do_reset();
    req = 8'hFF; en = 1'b1;
    step();
    check_eq("t034_pre", grant_valid, 32'd1);
    do_reset();
    req = 8'h10;
    step();
    check_eq("t034_id4", grant_id, 32'd4);
    release_pulse = 1'b1; step(); release_pulse = 1'b0;
    req = 8'hFF;
    wait_grant(8);
    check_eq("t034_ptr4", grant_id, 32'd5);

    // Randomized traffic checked every cycle by the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      else if ($urandom_range(0, 5) == 0) req = 8'h00;
      en            = ($urandom_range(0, 15) != 0);
      release_pulse = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_grant_sched.md
RR_GRANT_SCHED -- requirements
Module: rr_grant_sched

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive cycles one requester SHALL hold a grant; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  global enable; low SHALL block new grants and revoke any current grant.
REQ-005 req  input  8  level request per requester; bit i = requester i.
REQ-006 release  input  1  pulse from the current grantee ending its grant.
REQ-007 grant  output  8  one-hot grant, all-zero when idle.
REQ-008 grant_id  output  3  binary index of the current grantee; 0 when grant_valid is low.
REQ-009 grant_valid  output  1  high exactly when grant is nonzero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

Function
REQ-011 FSM states SHALL be IDLE, GRANT and GAP; encoding is free.
REQ-012 IDLE: if en=1 and req!=0, the winner SHALL be chosen; state SHALL go to GRANT with grant_valid=1 on the next edge (1-cycle latency); otherwise the block SHALL stay in IDLE.
REQ-013 Winner selection SHALL be round-robin: search indices ptr+1, ptr+2, ... mod 8; the first set req bit wins.
REQ-014 ptr SHALL be updated to the winner index on entry to GRANT; wrap 7->0 SHALL be seamless.
REQ-015 grant SHALL equal the 3-to-8 one-hot decode of grant_id while grant_valid=1, else 8'h00.
REQ-016 A hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT.
REQ-017 GRANT SHALL exit to GAP on the first edge where any of these holds: release=1; req[grant_id]=0; en=0; counter=MAX_HOLD-1.
REQ-018 timeout SHALL pulse for the cycle after the exit edge only when the counter limit was the sole exit cause; release, req drop or en=0 in the same cycle SHALL suppress it.
REQ-019 GAP SHALL last exactly one cycle with grant=0 and SHALL then go to IDLE; back-to-back grants are therefore separated by at least 2 idle cycles.
REQ-020 Changes to req bits other than req[grant_id] during GRANT SHALL NOT affect the current grant.
REQ-021 release outside GRANT SHALL be ignored.
REQ-022 en=0 SHALL NOT modify ptr.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 Reset assertion SHALL immediately force: state=IDLE, grant=8'h00, grant_id=0, grant_valid=0, timeout=0, counter=0, ptr=7, so requester 0 has first priority.
REQ-025 Reset assertion mid-grant SHALL drop the grant immediately, without passing through GAP.
REQ-026 After reset deassertion, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-027 A shared package SHALL hold the state enumeration, the NREQ=8 and IDW=3 constants and the default MAX_HOLD.
REQ-028 The one-hot decode SHALL be a sub-module, onehot_dec3to8 (3-bit index + enable in, 8-bit one-hot out, zero when disabled).
REQ-029 The round-robin search SHALL be combinational logic inside rr_grant_sched.

Verification
REQ-030 Reset, en=1, req=8'h81 -> grant=8'h01, grant_id=0 one cycle later; after release and GAP -> grant=8'h80, grant_id=7.
REQ-031 req=8'hFF held, release pulsed on each grant's 3rd cycle -> grant_id sequence 0,1,...,7,0; wrap occurs with no skipped index.
REQ-032 MAX_HOLD=4, req=8'h04 held, no release -> grant=8'h04 for exactly 4 cycles; timeout=1 for one cycle; 1 GAP cycle; regrant to 2.
REQ-033 During GRANT of requester 3, deassert en -> grant=0 on the next edge, timeout=0; re-enable -> the next grant continues the search from index 4.
REQ-034 rst_n pulsed low mid-grant -> all outputs zero immediately; after release of reset with req=8'h10 -> grant_id=4, ptr=4.
REQ-035 release and counter limit reached in the same cycle -> GAP entered, timeout stays 0.
